// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Bundles the pipeline-register taps and the hazard/mult-div status lines
//   that connect the hazard controller to the datapath.
//   master : datapath side (drives IR_D/IR_E/IR_M, observes the controls)
//   slave  : hazard controller side (observes the IRs, drives the controls)
//   Signals:
//     IR_D, IR_E, IR_M : 32-bit instructions held in ID, EX and MEM
//     stall            : freeze PC and IF/ID this cycle
//     flush_E          : load a bubble into ID/EX at the next edge
//     md_start         : one-cycle start pulse to the mult/div unit
//     md_busy          : mult/div unit is computing
//     stall_cnt        : 32-bit count of stalled cycles since reset
interface hazard_stall_ctrl_if;
  logic [31:0] IR_D;
  logic [31:0] IR_E;
  logic [31:0] IR_M;
  logic        stall;
  logic        flush_E;
  logic        md_start;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output IR_D, IR_E, IR_M,
    input  stall, flush_E, md_start, md_busy, stall_cnt
  );

  modport slave (
    input  IR_D, IR_E, IR_M,
    output stall, flush_E, md_start, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Hazard detection and HI/LO mult/div sequencing for the 5-stage MIPS core.
//   Raises stall (and the matching ID/EX flush) for load-use, branch-compare
//   and mult/div hazards, issues the mult/div start pulse and counts the
//   unit's latency.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : hazard_stall_ctrl_if.slave (IR_D/IR_E/IR_M in; stall, flush_E,
//             md_start, md_busy, stall_cnt out)
//   Parameters:
//     MULT_CYCLES : busy cycles for mult/multu (1..15)
//     DIV_CYCLES  : busy cycles for div/divu   (1..15)
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Destination register written by an instruction; 0 means "no writer".
  function automatic logic [4:0] dst_of(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h00, 6'h02, 6'h03, 6'h09, 6'h10, 6'h12,
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b: d = ir[15:11];
          default: d = 5'd0;
        endcase
      end
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: d = ir[20:16];
      6'h03: d = 5'd31;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  // Shifts by immediate, mfhi/mflo, lui, j and jal do not read rs.
  function automatic logic uses_rs(input logic [31:0] ir);
    logic u;
    u = 1'b1;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h00, 6'h02, 6'h03, 6'h10, 6'h12: u = 1'b0;
          default: u = 1'b1;
        endcase
      end
      6'h0f, 6'h02, 6'h03: u = 1'b0;
      default: u = 1'b1;
    endcase
    return u;
  endfunction

  // rt is read by R-type ALU ops (not jr/jalr/HI-LO moves), branches and stores.
  function automatic logic uses_rt(input logic [31:0] ir);
    logic u;
    u = 1'b0;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13: u = 1'b0;
          default: u = 1'b1;
        endcase
      end
      6'h04, 6'h05, 6'h28, 6'h29, 6'h2b: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic is_load(input logic [31:0] ir);
    logic l;
    case (ir[31:26])
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: l = 1'b1;
      default: l = 1'b0;
    endcase
    return l;
  endfunction

  // Branches that compare registers in ID: beq, bne, jr, jalr.
  function automatic logic is_branch(input logic [31:0] ir);
    logic b;
    case (ir[31:26])
      6'h04, 6'h05: b = 1'b1;
      6'h00: b = (ir[5:0] == 6'h08) || (ir[5:0] == 6'h09);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Any instruction touching HI/LO or the mult/div unit.
  function automatic logic is_md_class(input logic [31:0] ir);
    logic m;
    m = 1'b0;
    if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h10, 6'h11, 6'h12, 6'h13,
        6'h18, 6'h19, 6'h1a, 6'h1b: m = 1'b1;
        default: m = 1'b0;
      endcase
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

  // mult, multu, div, divu.
  function automatic logic is_md_starter(input logic [31:0] ir);
    logic m;
    if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h18, 6'h19, 6'h1a, 6'h1b: m = 1'b1;
        default: m = 1'b0;
      endcase
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

  // A source register in ID depends on a writer when it is non-zero, read, and equal.
  function automatic logic src_match(input logic [4:0] r, input logic used,
                                     input logic [4:0] d);
    return (r != 5'd0) && used && (r == d);
  endfunction

  md_state_t   state_r;
  md_state_t   state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [31:0] stall_cnt_r;

  logic [4:0]  rs_d_s;
  logic [4:0]  rt_d_s;
  logic        use_rs_s;
  logic        use_rt_s;
  logic        match_e_s;
  logic        match_m_s;
  logic        load_use_s;
  logic        branch_haz_s;
  logic        md_haz_s;
  logic        md_start_s;
  logic        md_busy_s;
  logic        stall_s;

  assign md_busy_s = (state_r == MD_BUSY);

  // Hazard detection and mult/div start decode.
  always_comb begin
    rs_d_s    = bus.IR_D[25:21];
    rt_d_s    = bus.IR_D[20:16];
    use_rs_s  = uses_rs(bus.IR_D);
    use_rt_s  = uses_rt(bus.IR_D);
    match_e_s = src_match(rs_d_s, use_rs_s, dst_of(bus.IR_E)) ||
                src_match(rt_d_s, use_rt_s, dst_of(bus.IR_E));
    match_m_s = src_match(rs_d_s, use_rs_s, dst_of(bus.IR_M)) ||
                src_match(rt_d_s, use_rt_s, dst_of(bus.IR_M));
    load_use_s   = is_load(bus.IR_E) && match_e_s;
    // Branches resolve in ID, so even an ALU result in EX is too late;
    // only a load still in MEM is a problem one stage further out.
    branch_haz_s = is_branch(bus.IR_D) &&
                   (match_e_s || (is_load(bus.IR_M) && match_m_s));
    // A starter arriving while BUSY is ignored; no pulse during reset.
    md_start_s   = !reset && is_md_starter(bus.IR_E) && (state_r == MD_IDLE);
    md_haz_s     = is_md_class(bus.IR_D) && (md_busy_s || md_start_s);
    stall_s      = load_use_s || branch_haz_s || md_haz_s;
  end

  // Mult/div sequencer next-state and latency counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      MD_IDLE: begin
        if (md_start_s) begin
          state_nxt_s = MD_BUSY;
          cnt_nxt_s   = bus.IR_E[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else begin
          state_nxt_s = MD_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      MD_BUSY: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = MD_IDLE;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = MD_BUSY;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = MD_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MD_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Free-running count of stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.flush_E   = stall_s;
  assign bus.md_start  = md_start_s;
  assign bus.md_busy   = md_busy_s;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Directed scenarios plus randomized instruction streams, checked every
//   cycle against a table-driven reference model of the hazard rules.
module tb_hazard_stall_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;

  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Decode tables built from the instruction lists.
  bit rd_f[64];
  bit rt_op[64];
  bit rs_skip_f[64];
  bit rt_skip_f[64];
  bit rt_use_op[64];
  bit load_op[64];
  bit md_f[64];

  // Model state: remaining busy cycles and stall count.
  int          md_rem;
  logic [31:0] cnt_m;
  logic        obs_stall;
  logic        obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_dst(input logic [31:0] ir);
    int op, fn;
    op = int'(ir[31:26]);
    fn = int'(ir[5:0]);
    if (op == 0 && rd_f[fn]) return int'(ir[15:11]);
    if (rt_op[op]) return int'(ir[20:16]);
    if (op == 3) return 31;
    return 0;
  endfunction

  function automatic bit m_uses_rs(input logic [31:0] ir);
    int op;
    op = int'(ir[31:26]);
    if (op == 0) return !rs_skip_f[int'(ir[5:0])];
    return !(op == 'h0f || op == 2 || op == 3);
  endfunction

  function automatic bit m_uses_rt(input logic [31:0] ir);
    int op;
    op = int'(ir[31:26]);
    if (op == 0) return !rt_skip_f[int'(ir[5:0])];
    return rt_use_op[op];
  endfunction

  function automatic bit m_depends(input logic [31:0] d, input logic [31:0] x);
    int w, rs, rt;
    w  = m_dst(x);
    rs = int'(d[25:21]);
    rt = int'(d[20:16]);
    if (w == 0) return 1'b0;
    return (m_uses_rs(d) && rs == w) || (m_uses_rt(d) && rt == w);
  endfunction

  function automatic bit m_branch(input logic [31:0] ir);
    int op, fn;
    op = int'(ir[31:26]);
    fn = int'(ir[5:0]);
    return op == 4 || op == 5 || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  function automatic bit m_starter(input logic [31:0] ir);
    int fn;
    fn = int'(ir[5:0]);
    return ir[31:26] == 6'd0 && fn >= 'h18 && fn <= 'h1b;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [4:0] a, b, c;
    logic [5:0] f;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    f = 6'($urandom_range(24, 27));
    case ($urandom_range(0, 20))
      0:  return 32'h0000_0000;
      1:  return {6'h00, a, b, c, 5'h00, 6'h21};
      2:  return {6'h09, a, b, 16'h0001};
      3:  return {6'h23, a, b, 16'h0000};
      4:  return {6'h04, a, b, 16'h0003};
      5:  return {6'h05, a, b, 16'h0003};
      6:  return {6'h00, a, 15'h0000, 6'h08};
      7:  return {6'h00, a, 5'h00, c, 5'h00, 6'h09};
      8:  return {6'h03, 26'h000_0010};
      9:  return {6'h2b, a, b, 16'h0000};
      10: return {6'h0f, 5'h00, b, 16'h0001};
      11, 12, 13, 14: return {6'h00, a, b, 10'h000, f};
      15: return {16'h0000, c, 5'h00, 6'h10};
      16: return {16'h0000, c, 5'h00, 6'h12};
      17: return {6'h00, a, 15'h0000, 6'h11};
      18: return {6'h00, a, 15'h0000, 6'h13};
      19: return {6'h20, a, b, 16'h0004};
      default: return {6'h00, 5'h00, b, c, 5'h03, 6'h00};
    endcase
  endfunction

  // One clock cycle: drive, check against the model at negedge, advance model.
  task automatic step(input logic [31:0] d, input logic [31:0] e,
                      input logic [31:0] m, input logic r);
    logic exp_start, exp_busy, exp_stall;
    bus.IR_D = d;
    bus.IR_E = e;
    bus.IR_M = m;
    reset    = r;
    exp_busy  = (md_rem > 0);
    exp_start = !r && !exp_busy && m_starter(e);
    exp_stall = (load_op[int'(e[31:26])] && m_depends(d, e)) ||
                (m_branch(d) && (m_depends(d, e) ||
                                 (load_op[int'(m[31:26])] && m_depends(d, m)))) ||
                (d[31:26] == 6'd0 && md_f[int'(d[5:0])] && (exp_busy || exp_start));
    @(negedge clk);
    check("stall",     {31'd0, bus.stall},    {31'd0, exp_stall});
    check("flush_E",   {31'd0, bus.flush_E},  {31'd0, exp_stall});
    check("md_start",  {31'd0, bus.md_start}, {31'd0, exp_start});
    check("md_busy",   {31'd0, bus.md_busy},  {31'd0, exp_busy});
    check("stall_cnt", bus.stall_cnt, cnt_m);
    obs_stall = bus.stall;
    obs_busy  = bus.md_busy;
    @(posedge clk);
    if (r) begin
      md_rem = 0;
      cnt_m  = 32'd0;
    end else begin
      if (exp_stall) cnt_m = cnt_m + 32'd1;
      if (md_rem > 0) md_rem--;
      else if (exp_start) md_rem = e[1] ? DIV_N : MULT_N;
    end
    #1;
  endtask

  initial begin
    int n_st, n_bz;
    byte unsigned l_rd[12]   = '{8'h00, 8'h02, 8'h03, 8'h09, 8'h10, 8'h12,
                                 8'h21, 8'h23, 8'h24, 8'h25, 8'h2a, 8'h2b};
    byte unsigned l_rt[12]   = '{8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e,
                                 8'h0f, 8'h20, 8'h21, 8'h23, 8'h24, 8'h25};
    byte unsigned l_rss[5]   = '{8'h00, 8'h02, 8'h03, 8'h10, 8'h12};
    byte unsigned l_rts[6]   = '{8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13};
    byte unsigned l_rtu[5]   = '{8'h04, 8'h05, 8'h28, 8'h29, 8'h2b};
    byte unsigned l_ld[5]    = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25};
    byte unsigned l_md[8]    = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19, 8'h1a, 8'h1b};
    foreach (l_rd[i])  rd_f[l_rd[i]]       = 1'b1;
    foreach (l_rt[i])  rt_op[l_rt[i]]      = 1'b1;
    foreach (l_rss[i]) rs_skip_f[l_rss[i]] = 1'b1;
    foreach (l_rts[i]) rt_skip_f[l_rts[i]] = 1'b1;
    foreach (l_rtu[i]) rt_use_op[l_rtu[i]] = 1'b1;
    foreach (l_ld[i])  load_op[l_ld[i]]    = 1'b1;
    foreach (l_md[i])  md_f[l_md[i]]       = 1'b1;

    md_rem   = 0;
    cnt_m    = 32'd0;
    reset    = 1'b1;
    bus.IR_D = 32'd0;
    bus.IR_E = 32'd0;
    bus.IR_M = 32'd0;
    @(posedge clk);
    #1;

    // Reset state and idle nops.
    step(32'd0, 32'd0, 32'd0, 1'b1);
    step(32'd0, 32'd0, 32'd0, 1'b0);
    step(32'd0, 32'd0, 32'd0, 1'b0);

    // Load-use: lw $8 in E, addu using $8 in D; then bubble; then unrelated addu.
    step(32'h010B5021, 32'h8D280000, 32'd0, 1'b0);
    check("lu_stall", {31'd0, obs_stall}, 32'd1);
    step(32'h010B5021, 32'd0, 32'h8D280000, 1'b0);
    check("lu_once", {31'd0, obs_stall}, 32'd0);
    check("lu_cnt", bus.stall_cnt, 32'd1);
    step(32'h018B5021, 32'h8D280000, 32'd0, 1'b0);
    check("lu_nomatch", {31'd0, obs_stall}, 32'd0);

    // Branch compare against ALU in E, load in M, and $0 destination.
    step(32'h10850003, 32'h24040001, 32'd0, 1'b0);
    check("br_alu_e", {31'd0, obs_stall}, 32'd1);
    step(32'h10850003, 32'd0, 32'h8D240000, 1'b0);
    check("br_load_m", {31'd0, obs_stall}, 32'd1);
    step(32'h10050003, 32'h24000001, 32'd0, 1'b0);
    check("br_zero", {31'd0, obs_stall}, 32'd0);

    // mult then dependent mflo: 6 stall cycles, 5 busy cycles.
    n_st = 0;
    n_bz = 0;
    step(32'h00003012, 32'h00430018, 32'd0, 1'b0);
    n_st += int'(obs_stall);
    for (int i = 0; i < 7; i++) begin
      step(32'h00003012, 32'd0, 32'd0, 1'b0);
      n_st += int'(obs_stall);
      n_bz += int'(obs_busy);
    end
    check("mult_stall_len", 32'(n_st), 32'd6);
    check("mult_busy_len", 32'(n_bz), 32'd5);

    // div then dependent mthi: 11 stall cycles, 10 busy cycles.
    n_st = 0;
    n_bz = 0;
    step(32'h00C00011, 32'h0043001A, 32'd0, 1'b0);
    n_st += int'(obs_stall);
    for (int i = 0; i < 13; i++) begin
      step(32'h00C00011, 32'd0, 32'd0, 1'b0);
      n_st += int'(obs_stall);
      n_bz += int'(obs_busy);
    end
    check("div_stall_len", 32'(n_st), 32'd11);
    check("div_busy_len", 32'(n_bz), 32'd10);

    // Reset in the 3rd busy cycle with mfhi pending.
    step(32'h00003010, 32'h00430018, 32'd0, 1'b0);
    step(32'h00003010, 32'd0, 32'd0, 1'b0);
    step(32'h00003010, 32'd0, 32'd0, 1'b0);
    step(32'h00003010, 32'd0, 32'd0, 1'b1);
    step(32'h00003010, 32'd0, 32'd0, 1'b0);
    check("rst_busy", {31'd0, obs_busy}, 32'd0);
    check("rst_stall", {31'd0, obs_stall}, 32'd0);
    check("rst_cnt", bus.stall_cnt, 32'd0);

    // Counter wrap from all-ones.
    force dut.stall_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_r;
    cnt_m = 32'hFFFF_FFFF;
    step(32'h010B5021, 32'h8D280000, 32'd0, 1'b0);
    step(32'd0, 32'd0, 32'd0, 1'b0);
    check("wrap", bus.stall_cnt, 32'd0);

    // Randomized streams with occasional reset.
    for (int i = 0; i < 800; i++) begin
      step(rand_ir(), rand_ir(), rand_ir(), 1'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and multiply/divide sequencing controller for the 5-stage MIPS core. It decodes the instructions held in the ID, EX and MEM pipeline registers. When an operand cannot be forwarded in time, it raises a stall that freezes PC and IF/ID and bubbles ID/EX. It also owns the HI/LO multiply/divide unit: it issues the start pulse, counts the unit's latency, and holds back dependent HI/LO instructions until the result is ready.

## Interface
- MULT_CYCLES, default 5, number of busy cycles for mult/multu (legal range 1–15).
- DIV_CYCLES, default 10, number of busy cycles for div/divu (legal range 1–15).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clk while high.
- IR_D  in  32  instruction in ID (output of IF/ID).
- IR_E  in  32  instruction in EX (output of ID/EX).
- IR_M  in  32  instruction in MEM (output of EX/MEM).
- stall  out  1  freeze PC and IF/ID this cycle.
- flush_E  out  1  load zero (nop) into ID/EX at the next edge; always equal to stall.
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_busy  out  1  the mult/div unit is computing.
- stall_cnt  out  32  number of cycles with stall=1 since reset.

## Operation
- Field decode: op = IR[31:26], rs = IR[25:21], rt = IR[20:16], rd = IR[15:11], funct = IR[5:0].
- Destination register dst(IR):
  - rd for op=0 with funct in {00,02,03,09,10,12,21,23,24,25,2a,2b}.
  - rt for op in {09,0a,0b,0c,0d,0e,0f,20,21,23,24,25}.
  - 31 for op=03 (jal).
  - Otherwise 0. A dst of 0 never causes a hazard.
- rs use in D (uses_rs): rs is read except for op=0 funct in {00,02,03,10,12}, op=0f, op=02 and op=03.
- rt use in D (uses_rt): rt is read for op=0 with funct not in {08,09,10,11,12,13}, and for op in {04,05,28,29,2b}.
- A register r in D "matches" X when r≠0, r is used (per uses_rs/uses_rt), and r == dst(IR_X).
- Load-use hazard: IR_E is a load (op in {20,21,23,24,25}) and it matches rs or rt in D.
- Branch-compare hazard: D holds beq/bne (op 04/05) or jr/jalr (op=0, funct 08/09), and either:
  - any writer in E matches, or
  - a load in M matches.
- MD-class instructions: op=0 with funct in {10,11,12,13,18,19,1a,1b}. MD starters are funct 18/19/1a/1b.
- MD hazard: D holds an MD-class instruction and (md_busy=1 or md_start=1).
- stall = load-use hazard OR branch-compare hazard OR MD hazard. It is combinational from the IR inputs and registered state.
- md_start = 1 when IR_E is an MD starter and the FSM is in IDLE.
- MD FSM:
  - IDLE: on md_start, load cnt with MULT_CYCLES (funct 18/19) or DIV_CYCLES (funct 1a/1b) and go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, go to IDLE. md_busy=1 throughout BUSY.
- cnt is 4 bits wide.
- stall_cnt increments by 1 on every edge with stall=1 and reset=0. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: FSM=IDLE, cnt=0, md_busy=0, stall_cnt=0.
- With all IR inputs zero (nop): stall=0, flush_E=0, md_start=0.
- A stall asserted in cycle t holds PC and IF/ID at edge t+1 and places a bubble in EX for cycle t+1.
- A load-use stall lasts exactly 1 cycle.
- A branch-compare stall against an ALU writer in E lasts 1 cycle. Against a load in E it lasts 2 cycles: one as load-use/E, then one as load/M.
- MD timing, for a starter in E at cycle t:
  - md_start=1 at cycle t.
  - md_busy=1 for cycles t+1 … t+N, where N is the applicable parameter.
  - A dependent MD-class instruction in D stalls from t through t+N and enters EX at t+N+1.
- An MD starter in E while in BUSY cannot occur, because the D stage stalled it. If it does occur, it is ignored: no restart, md_start=0.
- Reset mid-operation: BUSY returns to IDLE and cnt clears at the reset edge. No md_start is issued while reset=1.
- Simultaneous events: stall is the OR of all hazards, and the stall count increments by exactly 1 per stalled cycle.

## Test plan
- Load-use: IR_E=lw $8,0($9) (0x8D280000), IR_D=addu $10,$8,$11 (0x010B5021) → stall=flush_E=1 for 1 cycle, and stall_cnt goes 0→1. The same pair with IR_D=addu $10,$12,$11 gives stall=0.
- Branch-compare: IR_E=addiu $4,$0,1 (0x24040001), IR_D=beq $4,$5,... (0x10850003) → stall=1. With the load lw $4 in IR_M instead → stall=1. With $0 as the destination → stall=0.
- Mult latency: mult $2,$3 (0x00430018) in E at t0, mflo $6 (0x00003012) in D → md_start=1 at t0, md_busy=1 for t0+1..t0+5, and stall=1 for t0..t0+5 (6 cycles).
- Div with DIV_CYCLES=10: md_busy stays high for exactly 10 cycles, and an mthi in D stalls for 11 cycles.
- Reset mid-BUSY: reset at the 3rd BUSY cycle → next cycle md_busy=0, stall_cnt=0, stall=0 for a pending mfhi.
- Wrap: force stall_cnt=0xFFFFFFFF, then one stalled cycle → stall_cnt=0.
